// File: rtl/display_selftest_scanner_if.sv
// Signal bundle between application logic / board pins and display_selftest_scanner.
interface display_selftest_scanner_if #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int DIGITS      = 6,
  parameter int DIGIT_LINES = 8
);
  logic                   start;
  logic [ROWS*COLS-1:0]   lattice_data;
  logic [DIGITS*8-1:0]    seg_data;
  logic [ROWS-1:0]        row;
  logic [COLS-1:0]        col;
  logic [DIGIT_LINES-1:0] digit_cath;
  logic [7:0]             digit_seg;
  logic                   busy;
  logic                   done;

  modport master (
    output start, lattice_data, seg_data,
    input  row, col, digit_cath, digit_seg, busy, done
  );

  modport slave (
    input  start, lattice_data, seg_data,
    output row, col, digit_cath, digit_seg, busy, done
  );
endinterface

// File: rtl/display_selftest_scanner.sv
// LED lattice + multiplexed 7-seg scanner with lamp self-test.
// Define SELFTEST_AUTOSTART_EN to run the self-test automatically after every reset.
//
// state  | meaning
// IDLE   | first cycle after reset only
// TEST   | blinking every lamp/segment BLINKS times
// NORMAL | showing caller frame and segment data
module display_selftest_scanner #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int DIGITS      = 6,
  parameter int DIGIT_LINES = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int BLINKS      = 3
) (
  input logic                      clk,
  input logic                      rst,
  display_selftest_scanner_if.slave bus
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PW = (BLINKS    > 1) ? $clog2(BLINKS)    : 1;
  localparam int RW = (ROWS      > 1) ? $clog2(ROWS)      : 1;
  localparam int DW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PAIR_LAST  = PW'(BLINKS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, TEST, NORMAL} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   scan_cnt, scan_cnt_nxt;
  logic [RW-1:0]   row_idx, row_nxt;
  logic [DW-1:0]   dig_idx, dig_nxt;
  logic [BW-1:0]   blink_cnt, blink_cnt_nxt;
  logic [PW-1:0]   pair_cnt, pair_nxt;
  logic            phase, phase_nxt;   // 0 = ON, 1 = OFF
  logic            tick, blink_wrap;

  logic [ROWS-1:0]        row_q, row_d;
  logic [COLS-1:0]        col_q, col_d;
  logic [DIGIT_LINES-1:0] cath_q, cath_d;
  logic [7:0]             seg_q, seg_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scan_cnt  <= '0;
      row_idx   <= '0;
      dig_idx   <= '0;
      blink_cnt <= '0;
      pair_cnt  <= '0;
      phase     <= 1'b0;
      row_q     <= '1;
      col_q     <= '0;
      cath_q    <= '1;
      seg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      scan_cnt  <= scan_cnt_nxt;
      row_idx   <= row_nxt;
      dig_idx   <= dig_nxt;
      blink_cnt <= blink_cnt_nxt;
      pair_cnt  <= pair_nxt;
      phase     <= phase_nxt;
      row_q     <= row_d;
      col_q     <= col_d;
      cath_q    <= cath_d;
      seg_q     <= seg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    tick         = (scan_cnt == SCAN_LAST);
    scan_cnt_nxt = tick ? '0 : scan_cnt + 1'b1;
    row_nxt      = row_idx;
    dig_nxt      = dig_idx;
    if (tick) begin
      row_nxt = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
      dig_nxt = (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
    end

    blink_wrap = (blink_cnt == BLINK_LAST);
    state_nxt  = state;
    case (state)
`ifdef SELFTEST_AUTOSTART_EN
      IDLE:    state_nxt = TEST;
`else
      IDLE:    state_nxt = NORMAL;
`endif
      NORMAL:  if (bus.start) state_nxt = TEST;
      TEST:    if (blink_wrap && phase && (pair_cnt == PAIR_LAST)) state_nxt = NORMAL;
      default: state_nxt = IDLE;
    endcase

    // Blink counters sit at zero outside TEST, so entering TEST always starts clean.
    blink_cnt_nxt = '0;
    phase_nxt     = 1'b0;
    pair_nxt      = '0;
    if (state == TEST && state_nxt == TEST) begin
      blink_cnt_nxt = blink_wrap ? '0 : blink_cnt + 1'b1;
      phase_nxt     = blink_wrap ? ~phase : phase;
      pair_nxt      = (blink_wrap && phase) ? pair_cnt + 1'b1 : pair_cnt;
    end
  end

  // Outputs are built from next-cycle values so all pins update on the same edge.
  always_comb begin
    row_d  = ~(ROWS'(1) << row_nxt);
    cath_d = ~(DIGIT_LINES'(1) << dig_nxt);
    col_d  = '0;
    seg_d  = '0;
    busy_d = (state_nxt == TEST);
    done_d = (state == TEST) && (state_nxt == NORMAL);
    if (state_nxt == TEST) begin
      if (!phase_nxt) begin
        col_d = '1;
        seg_d = 8'hFF;
      end
    end else if (state_nxt == NORMAL) begin
      col_d = bus.lattice_data[row_nxt*COLS +: COLS];
      seg_d = bus.seg_data[dig_nxt*8 +: 8];
    end
  end

  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.digit_cath = cath_q;
  assign bus.digit_seg  = seg_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_display_selftest_scanner.sv
// Directed bench for display_selftest_scanner (4x4 lattice, 3 of 4 digit lines).
module tb_display_selftest_scanner;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  display_selftest_scanner_if #(.ROWS(4), .COLS(4), .DIGITS(3), .DIGIT_LINES(4)) dif ();

  display_selftest_scanner #(
    .ROWS(4), .COLS(4), .DIGITS(3), .DIGIT_LINES(4),
    .SCAN_DIV(4), .BLINK_DIV(10), .BLINKS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  // expected scan outputs for lattice 16'h8421 and segs 3F/06/5B
  logic [3:0] row_t  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [3:0] col_t  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [3:0] cath_t [3] = '{4'hE, 4'hD, 4'hB};
  logic [7:0] seg_t  [3] = '{8'h3F, 8'h06, 8'h5B};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) cyc = 0;
    else     cyc++;
  endtask

  task automatic check_scan(input string tag);
    int ri, di;
    ri = (cyc / 4) % 4;
    di = (cyc / 4) % 3;
    check({tag, ".row"},   dif.row,           row_t[ri]);
    check({tag, ".col"},   dif.col,           col_t[ri]);
    check({tag, ".cath"},  dif.digit_cath,    cath_t[di]);
    check({tag, ".seg"},   dif.digit_seg,     seg_t[di]);
    check({tag, ".cath3"}, dif.digit_cath[3], 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".row"},  dif.row,        4'hF);
    check({tag, ".col"},  dif.col,        4'h0);
    check({tag, ".cath"}, dif.digit_cath, 4'hF);
    check({tag, ".seg"},  dif.digit_seg,  8'h00);
    check({tag, ".busy"}, dif.busy,       0);
    check({tag, ".done"}, dif.done,       0);
  endtask

  // Entered with test cycle 1 already sampled-ready; checks the whole 40-cycle blink run.
  task automatic run_test_check(input bit retrig);
    bit on;
    for (int c = 1; c <= 40; c++) begin
      on = (((c - 1) / 10) % 2 == 0);
      check("test.busy", dif.busy,      1);
      check("test.done", dif.done,      0);
      check("test.col",  dif.col,       on ? 4'hF : 4'h0);
      check("test.seg",  dif.digit_seg, on ? 8'hFF : 8'h00);
      dif.start = retrig && (c == 5 || c == 15);
      step();
    end
    dif.start = 1'b0;
    check("end.busy", dif.busy, 0);
    check("end.done", dif.done, 1);
    step();
    check("end.done_clr", dif.done, 0);
    check_scan("post");
  endtask

  initial begin
    rst              = 1'b1;
    dif.start        = 1'b0;
    dif.lattice_data = 16'h8421;
    dif.seg_data     = 24'h5B063F;
    repeat (3) step();
    check_reset("rst");
    rst = 1'b0;

`ifdef SELFTEST_AUTOSTART_EN
    step();
    run_test_check(1'b0);
`else
    for (int i = 0; i < 3; i++) begin
      step();
      check("noauto.busy", dif.busy, 0);
      check_scan("noauto");
    end
`endif

    for (int i = 0; i < 20; i++) begin
      step();
      check_scan("scan");
    end

    dif.lattice_data = 16'hFFFF;
    step();
    check("data.col", dif.col, 4'hF);
    dif.lattice_data = 16'h8421;
    step();
    check_scan("data");

    dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    run_test_check(1'b0);

    for (int i = 0; i < 5; i++) begin
      step();
      check_scan("gap");
    end

    dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    run_test_check(1'b1);

    dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    for (int c = 1; c < 25; c++) begin
      check("abort.busy", dif.busy, 1);
      check("abort.done", dif.done, 0);
      step();
    end
    rst = 1'b1;
    step();
    check_reset("abort");
    step();
    check_reset("abort_hold");
    rst = 1'b0;

`ifdef SELFTEST_AUTOSTART_EN
    step();
    run_test_check(1'b0);
`else
    for (int i = 0; i < 6; i++) begin
      step();
      check("rerun.busy", dif.busy, 0);
      check("rerun.done", dif.done, 0);
      check_scan("rerun");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
